// File: rtl/leaf_user_in_buffer_pkg.sv
// Shared leaf definitions for the user-side input buffer.
// Holds the default payload/port/FIFO/counter sizing and the payload type
// used by the buffer top and its per-port FIFO.
package leaf_user_in_buffer_pkg;

  localparam int unsigned PAYLOAD_BITS = 32;
  localparam int unsigned NUM_IN_PORTS = 6;
  localparam int unsigned FIFO_AW      = 3;
  localparam int unsigned FIFO_DEPTH   = 1 << FIFO_AW;
  localparam int unsigned CNT_BITS     = 32;

  // Flattened bus widths for the per-port vectors at the top level
  localparam int unsigned DATA_BUS_BITS = NUM_IN_PORTS * PAYLOAD_BITS;
  localparam int unsigned CNT_BUS_BITS  = NUM_IN_PORTS * CNT_BITS;

  typedef logic [PAYLOAD_BITS-1:0] payload_t;

endpackage

// File: rtl/leaf_user_in_fifo.sv
// Synchronous show-ahead FIFO on distributed RAM.
// Ports:
//   clk_user, reset   clock and synchronous active-high reset (clears pointers)
//   din, wr_en, full  write side; a write while full is ignored
//   dout, rd_en, empty read side; dout is the current head, rd_en pops it
// While empty, dout keeps showing the most recently popped word.
module leaf_user_in_fifo
  import leaf_user_in_buffer_pkg::*;
#(
  parameter int unsigned DATA_BITS = PAYLOAD_BITS,
  parameter int unsigned ADDR_BITS = FIFO_AW
) (
  input  logic                 clk_user,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 wr_en,
  output logic                 full,
  output logic [DATA_BITS-1:0] dout,
  input  logic                 rd_en,
  output logic                 empty
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [ADDR_BITS:0]   wr_ptr;
  logic [ADDR_BITS:0]   rd_ptr;
  logic [ADDR_BITS-1:0] last_idx;
  logic                 do_wr;
  logic                 do_rd;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign full  = (wr_ptr[ADDR_BITS] != rd_ptr[ADDR_BITS]) &&
                 (wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  // Pointer registers
  always_ff @(posedge clk_user) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (ADDR_BITS+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (ADDR_BITS+1)'(1);
    end
  end

  // Storage array, no reset so it maps onto LUT RAM
  always_ff @(posedge clk_user) begin
    if (do_wr) mem[wr_ptr[ADDR_BITS-1:0]] <= din;
  end

  // When empty the slot behind rd_ptr is the last word popped; it cannot be
  // overwritten until the FIFO has refilled past that slot.
  assign last_idx = rd_ptr[ADDR_BITS-1:0] - ADDR_BITS'(1);
  assign dout     = empty ? mem[last_idx] : mem[rd_ptr[ADDR_BITS-1:0]];

endmodule

// File: rtl/leaf_user_in_buffer.sv
// Per-port input buffering between the leaf interface and an HLS kernel.
// Ports:
//   clk_user, reset              user clock, synchronous active-high reset
//   dout_leaf_interface2user     port p payload at [p*PAYLOAD_BITS +: PAYLOAD_BITS]
//   vld_interface2user           port p word available
//   ack_user2interface           port p word consumed this cycle (combinational)
//   kdata, kvalid, kready        show-ahead valid/ready stream per port to the kernel
//   word_cnt                     per-port count of accepted words (wraps)
module leaf_user_in_buffer #(
  parameter int unsigned PAYLOAD_BITS = leaf_user_in_buffer_pkg::PAYLOAD_BITS,
  parameter int unsigned NUM_IN_PORTS = leaf_user_in_buffer_pkg::NUM_IN_PORTS,
  parameter int unsigned FIFO_AW      = leaf_user_in_buffer_pkg::FIFO_AW,
  parameter int unsigned CNT_BITS     = leaf_user_in_buffer_pkg::CNT_BITS
) (
  input  logic                             clk_user,
  input  logic                             reset,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0] dout_leaf_interface2user,
  input  logic [NUM_IN_PORTS-1:0]          vld_interface2user,
  output logic [NUM_IN_PORTS-1:0]          ack_user2interface,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0] kdata,
  output logic [NUM_IN_PORTS-1:0]          kvalid,
  input  logic [NUM_IN_PORTS-1:0]          kready,
  output logic [NUM_IN_PORTS*CNT_BITS-1:0] word_cnt
);

  logic [NUM_IN_PORTS-1:0] fifo_full;
  logic [NUM_IN_PORTS-1:0] fifo_empty;
  logic [CNT_BITS-1:0]     cnt_q [NUM_IN_PORTS];

  // Accept only when there is room before any pop this cycle, so ack has no
  // combinational dependency on kready.
  always_comb begin
    ack_user2interface = '0;
    ack_user2interface = vld_interface2user & ~fifo_full & {NUM_IN_PORTS{~reset}};
  end

  for (genvar p = 0; p < NUM_IN_PORTS; p++) begin : g_port

    leaf_user_in_fifo #(
      .DATA_BITS (PAYLOAD_BITS),
      .ADDR_BITS (FIFO_AW)
    ) u_fifo (
      .clk_user (clk_user),
      .reset    (reset),
      .din      (dout_leaf_interface2user[p*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .wr_en    (ack_user2interface[p]),
      .full     (fifo_full[p]),
      .dout     (kdata[p*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .rd_en    (kready[p]),
      .empty    (fifo_empty[p])
    );

    assign kvalid[p] = ~fifo_empty[p];

    // Accepted-word counter, free-running wrap
    always_ff @(posedge clk_user) begin
      if (reset) begin
        cnt_q[p] <= '0;
      end else if (ack_user2interface[p]) begin
        cnt_q[p] <= cnt_q[p] + CNT_BITS'(1);
      end
    end

    assign word_cnt[p*CNT_BITS +: CNT_BITS] = cnt_q[p];

  end

endmodule

// File: tb/tb_leaf_user_in_buffer.sv
module tb_leaf_user_in_buffer;

  localparam int unsigned N    = 6;
  localparam int unsigned DW   = 32;
  localparam int unsigned FLAT = N * DW;
  localparam int unsigned DEP  = 8;

  logic            clk_user = 1'b0;
  logic            reset;
  logic [FLAT-1:0] din;
  logic [N-1:0]    vld, ack, kvalid, kready;
  logic [FLAT-1:0] kdata, word_cnt;

  always #5 clk_user = ~clk_user;

  leaf_user_in_buffer dut (
    .clk_user                 (clk_user),
    .reset                    (reset),
    .dout_leaf_interface2user (din),
    .vld_interface2user       (vld),
    .ack_user2interface       (ack),
    .kdata                    (kdata),
    .kvalid                   (kvalid),
    .kready                   (kready),
    .word_cnt                 (word_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: one queue of buffered words and one word count per port
  logic [DW-1:0] mq [N][$];
  logic [DW-1:0] mcnt [N];
  logic [DW-1:0] got [$];

  logic [N-1:0]    obs_ack, obs_kv;
  logic [FLAT-1:0] obs_kd, obs_cnt;

  typedef struct {
    logic          r;
    logic [N-1:0]  v;
    logic [N-1:0]  kr;
    logic [DW-1:0] d0;
    logic [N-1:0]  e_ack;
    logic [N-1:0]  e_kv;
    logic          ck_kd;
    logic [DW-1:0] e_kd0;
    logic [DW-1:0] e_cnt0;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [FLAT-1:0] act, input logic [FLAT-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one cycle (called at a falling edge), compare against the model
  // mid-cycle, then advance the model across the rising edge.
  task automatic step(input logic r, input logic [N-1:0] v, input logic [N-1:0] kr);
    logic [N-1:0]    e_ack, e_kv;
    logic [FLAT-1:0] e_kd, mask, e_cnt;
    reset = r; vld = v; kready = kr;
    #1;
    e_ack = '0; e_kv = '0; e_kd = '0; mask = '0; e_cnt = '0;
    for (int p = 0; p < N; p++) begin
      e_ack[p] = v[p] && !r && (mq[p].size() < DEP);
      e_kv[p]  = (mq[p].size() != 0);
      if (e_kv[p]) begin
        e_kd[p*DW +: DW] = mq[p][0];
        mask[p*DW +: DW] = '1;
      end
      e_cnt[p*DW +: DW] = mcnt[p];
    end
    obs_ack = ack; obs_kv = kvalid; obs_kd = kdata; obs_cnt = word_cnt;
    chk("ack", FLAT'(ack), FLAT'(e_ack));
    chk("kvalid", FLAT'(kvalid), FLAT'(e_kv));
    chk("kdata", kdata & mask, e_kd);
    chk("word_cnt", word_cnt, e_cnt);
    @(posedge clk_user);
    for (int p = 0; p < N; p++) begin
      if (r) begin
        mq[p].delete();
        mcnt[p] = '0;
      end else begin
        if (e_kv[p] && kr[p]) void'(mq[p].pop_front());
        if (e_ack[p]) begin
          mq[p].push_back(din[p*DW +: DW]);
          mcnt[p] = mcnt[p] + 32'd1;
        end
      end
    end
    @(negedge clk_user);
  endtask

  initial begin
    int            acks;
    logic [DW-1:0] nxt;
    logic          ok;
    int            sent [N];
    logic [N-1:0]  v, kr;
    int            cyc;
    logic          busy;

    for (int p = 0; p < N; p++) mcnt[p] = '0;
    reset = 1'b1; vld = '0; kready = '0; din = '0;
    @(posedge clk_user); @(posedge clk_user); @(negedge clk_user);

    //            r     v      kr     d0            e_ack  e_kv   ck  e_kd0         e_cnt0
    tbl[0] = '{1'b1, 6'h3F, 6'h00, 32'h0,        6'h00, 6'h00, 0, 32'h0,        32'd0};
    tbl[1] = '{1'b1, 6'h3F, 6'h00, 32'h0,        6'h00, 6'h00, 0, 32'h0,        32'd0};
    tbl[2] = '{1'b1, 6'h3F, 6'h00, 32'h0,        6'h00, 6'h00, 0, 32'h0,        32'd0};
    tbl[3] = '{1'b0, 6'h01, 6'h3F, 32'hDEADBEEF, 6'h01, 6'h00, 0, 32'h0,        32'd0};
    tbl[4] = '{1'b0, 6'h00, 6'h3F, 32'h0,        6'h00, 6'h01, 1, 32'hDEADBEEF, 32'd1};
    tbl[5] = '{1'b0, 6'h00, 6'h3F, 32'h0,        6'h00, 6'h00, 0, 32'h0,        32'd1};

    for (int i = 0; i < 6; i++) begin
      din[DW-1:0] = tbl[i].d0;
      step(tbl[i].r, tbl[i].v, tbl[i].kr);
      chk("tbl_ack", FLAT'(obs_ack), FLAT'(tbl[i].e_ack));
      chk("tbl_kvalid", FLAT'(obs_kv), FLAT'(tbl[i].e_kv));
      chk("tbl_cnt0", FLAT'(obs_cnt[DW-1:0]), FLAT'(tbl[i].e_cnt0));
      if (tbl[i].ck_kd) chk("tbl_kdata0", FLAT'(obs_kd[DW-1:0]), FLAT'(tbl[i].e_kd0));
    end

    // Fill port 3 with the kernel stalled
    acks = 0; nxt = 32'd1;
    for (int c = 0; c < 10; c++) begin
      din[3*DW +: DW] = nxt;
      step(1'b0, 6'b001000, 6'b000000);
      if (obs_ack[3]) begin acks++; nxt = nxt + 32'd1; end
    end
    chk("fill_acks", FLAT'(acks), FLAT'(8));
    chk("full_ack_low", FLAT'(obs_ack[3]), FLAT'(0));

    // Pop while full: no ack that cycle, ack returns the next
    got.delete();
    din[3*DW +: DW] = nxt;
    step(1'b0, 6'b001000, 6'b001000);
    chk("full_pop_no_ack", FLAT'(obs_ack[3]), FLAT'(0));
    chk("full_pop_head", FLAT'(obs_kd[3*DW +: DW]), FLAT'(32'd1));
    if (obs_kv[3]) got.push_back(obs_kd[3*DW +: DW]);
    step(1'b0, 6'b001000, 6'b001000);
    chk("ack_resume", FLAT'(obs_ack[3]), FLAT'(1));
    if (obs_kv[3]) got.push_back(obs_kd[3*DW +: DW]);
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 6'b000000, 6'b001000);
      if (obs_kv[3]) got.push_back(obs_kd[3*DW +: DW]);
    end
    chk("drain_len", FLAT'(got.size()), FLAT'(9));
    ok = (got.size() == 9);
    for (int i = 0; i < got.size(); i++) if (got[i] !== 32'(i + 1)) ok = 1'b0;
    chk("drain_order", FLAT'(ok), FLAT'(1));

    // Reset with words buffered on port 1
    for (int i = 0; i < 5; i++) begin
      din[1*DW +: DW] = 32'd100 + 32'(i);
      step(1'b0, 6'b000010, 6'b000000);
    end
    step(1'b1, 6'b000010, 6'b000000);
    din[1*DW +: DW] = 32'h1234;
    step(1'b0, 6'b000010, 6'b000000);
    chk("rst_kvalid1", FLAT'(obs_kv[1]), FLAT'(0));
    chk("rst_cnt1", FLAT'(obs_cnt[1*DW +: DW]), FLAT'(0));
    chk("rst_ack1", FLAT'(obs_ack[1]), FLAT'(1));
    step(1'b0, 6'b000000, 6'b000010);
    chk("rst_kvalid1_new", FLAT'(obs_kv[1]), FLAT'(1));
    chk("rst_kdata1_new", FLAT'(obs_kd[1*DW +: DW]), FLAT'(32'h1234));

    // All ports streaming 100 random words with random back-pressure
    step(1'b1, 6'b000000, 6'b000000);
    for (int p = 0; p < N; p++) sent[p] = 0;
    cyc = 0; busy = 1'b1;
    while (busy && cyc < 3000) begin
      for (int p = 0; p < N; p++) begin
        din[p*DW +: DW] = $urandom;
        v[p]  = (sent[p] < 100) && ($urandom_range(0, 3) != 0);
        kr[p] = $urandom_range(0, 1) == 1;
      end
      step(1'b0, v, kr);
      for (int p = 0; p < N; p++) if (obs_ack[p]) sent[p]++;
      busy = 1'b0;
      for (int p = 0; p < N; p++) if (sent[p] < 100 || mq[p].size() != 0) busy = 1'b1;
      cyc++;
    end
    chk("rand_done", FLAT'(busy), FLAT'(0));
    step(1'b0, 6'b000000, 6'b000000);
    for (int p = 0; p < N; p++)
      chk("rand_cnt", FLAT'(obs_cnt[p*DW +: DW]), FLAT'(100));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
